// File: rtl/frame_scheduler.sv
// Camera frame scheduler: arms on a downlink command, captures between vsync edges, drains the buffer, repeats.
// Optional FRAME_SCHED_OVERFLOW_ABORT_EN: fifo_full during CAPTURE aborts the capture straight into DRAIN.
module frame_scheduler #(
  parameter int GAP_CYCLES  = 1024,
  parameter int DRAIN_IDLE  = 16,
  parameter int ARM_TIMEOUT = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_resolution,
  input  logic [2:0] cmd_compression,
  input  logic [3:0] cmd_repetition,
  input  logic       vsync,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  output logic       capture_en,
  output logic [2:0] compress_command,
  output logic       camera_res,
  output logic       tx_trigger,
  output logic       busy,
  output logic [7:0] frame_count,
  output logic       overflow,
  output logic       timeout,
  output logic       cmd_dropped
);

  localparam int MAX_A   = (GAP_CYCLES > DRAIN_IDLE) ? GAP_CYCLES : DRAIN_IDLE;
  localparam int MAX_CNT = (MAX_A > ARM_TIMEOUT) ? MAX_A : ARM_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] ARM_LAST   = CNT_W'(ARM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_IDLE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DRAIN, GAP} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       vsync_sync_reg;
  logic             vsync_edge;
  logic             frame_done;
  logic             abort_now;
  logic             res_reg;
  logic [2:0]       comp_reg;
  logic [3:0]       rep_left_reg;
  logic [7:0]       frame_count_reg;
  logic             overflow_reg;
  logic             cmd_dropped_reg;

  // Bits [1:0] are the synchronizer; bit 2 is the previous synchronized value for edge detection.
  assign vsync_edge = vsync_sync_reg[1] & ~vsync_sync_reg[2];

`ifdef FRAME_SCHED_OVERFLOW_ABORT_EN
  assign abort_now = fifo_full;
`else
  assign abort_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      vsync_sync_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      vsync_sync_reg <= {vsync_sync_reg[1:0], vsync};
    end
  end

  // One shared counter: ARM timeout, consecutive-empty drain count, and GAP length.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    frame_done = 1'b0;
    timeout    = 1'b0;
    capture_en = 1'b0;
    tx_trigger = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (cmd_valid) state_next = ARM;
      end
      ARM: begin
        if (vsync_edge) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else if (cnt_reg == ARM_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          timeout    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        tx_trigger = 1'b1;
        if (vsync_edge || abort_now) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end
      end
      DRAIN: begin
        tx_trigger = 1'b1;
        if (!fifo_empty) begin
          cnt_next = '0;
        end else if (cnt_reg == DRAIN_LAST) begin
          frame_done = 1'b1;
          cnt_next   = '0;
          state_next = (rep_left_reg <= 4'd1) ? IDLE : GAP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = ARM;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg         <= 1'b0;
      comp_reg        <= '0;
      rep_left_reg    <= '0;
      frame_count_reg <= '0;
      overflow_reg    <= 1'b0;
      cmd_dropped_reg <= 1'b0;
    end else begin
      cmd_dropped_reg <= cmd_valid && (state_reg != IDLE);
      if (state_reg == IDLE && cmd_valid) begin
        res_reg      <= cmd_resolution;
        comp_reg     <= cmd_compression;
        rep_left_reg <= (cmd_repetition == 4'd0) ? 4'd1 : cmd_repetition;
        overflow_reg <= 1'b0;
      end else begin
        if (state_reg == CAPTURE && fifo_full) overflow_reg <= 1'b1;
        if (frame_done) begin
          frame_count_reg <= frame_count_reg + 8'd1;
          rep_left_reg    <= rep_left_reg - 4'd1;
        end
      end
    end
  end

  assign compress_command = comp_reg;
  assign camera_res       = res_reg;
  assign frame_count      = frame_count_reg;
  assign overflow         = overflow_reg;
  assign cmd_dropped      = cmd_dropped_reg;

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: scoreboard of expected frame completions plus per-scenario timing checks.
module tb_frame_scheduler;
  localparam int GAP_CYCLES  = 1024;
  localparam int DRAIN_IDLE  = 16;
  localparam int ARM_TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_resolution = 1'b0;
  logic [2:0] cmd_compression = 3'd0;
  logic [3:0] cmd_repetition = 4'd0;
  logic       vsync = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_full = 1'b0;
  logic       capture_en;
  logic [2:0] compress_command;
  logic       camera_res;
  logic       tx_trigger;
  logic       busy;
  logic [7:0] frame_count;
  logic       overflow;
  logic       timeout;
  logic       cmd_dropped;

  always #5 clk = ~clk;

  frame_scheduler #(
    .GAP_CYCLES (GAP_CYCLES),
    .DRAIN_IDLE (DRAIN_IDLE),
    .ARM_TIMEOUT(ARM_TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_resolution  (cmd_resolution),
    .cmd_compression (cmd_compression),
    .cmd_repetition  (cmd_repetition),
    .vsync           (vsync),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .capture_en      (capture_en),
    .compress_command(compress_command),
    .camera_res      (camera_res),
    .tx_trigger      (tx_trigger),
    .busy            (busy),
    .frame_count     (frame_count),
    .overflow        (overflow),
    .timeout         (timeout),
    .cmd_dropped     (cmd_dropped)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] fc;
    logic [2:0] comp;
    logic       res;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fc_model = 8'd0;

  function automatic logic [17:0] all_outputs();
    return {capture_en, compress_command, camera_res, tx_trigger, busy,
            frame_count, overflow, timeout, cmd_dropped};
  endfunction

  task automatic push_frames(input int n, input logic [2:0] comp, input logic res);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      fc_model = fc_model + 8'd1;
      e.fc = fc_model;
      e.comp = comp;
      e.res = res;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic res, input logic [2:0] comp, input logic [3:0] rep);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_resolution = res;
    cmd_compression = comp;
    cmd_repetition = rep;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic wait_cap(input logic val, input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i <= budget; i++) begin
      if (capture_en === val) begin
        cyc = i;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_frame(input int budget, output int cyc);
    logic [7:0] prev;
    prev = frame_count;
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (frame_count !== prev) begin
        cyc = i;
        return;
      end
    end
  endtask

  // From ARM: vsync -> CAPTURE, 40 cycles, vsync -> DRAIN, then empty fifo until the frame completes.
  task automatic run_frame(output bit ok, output int drain_cyc);
    int c;
    ok = 1'b1;
    pulse_vsync();
    wait_cap(1'b1, 10, c);
    if (c < 0) ok = 1'b0;
    fifo_empty = 1'b0;
    repeat (40) @(negedge clk);
    pulse_vsync();
    wait_cap(1'b0, 10, c);
    if (c < 0) ok = 1'b0;
    fifo_empty = 1'b1;
    wait_frame(DRAIN_IDLE + 10, drain_cyc);
    if (drain_cyc < 0) ok = 1'b0;
  endtask

  task automatic pop_and_compare(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: frame completed with no expected entry (fc=%0d)", name, frame_count);
      return;
    end
    e = exp_q.pop_front();
    if ({frame_count, compress_command, camera_res} !== e) begin
      failures++;
      $display("FAIL %s: got fc=%0d comp=%0d res=%0d, expected fc=%0d comp=%0d res=%0d",
               name, frame_count, compress_command, camera_res, e.fc, e.comp, e.res);
    end else begin
      $display("frame %s fc=%0d comp=%0d res=%0d", name, frame_count, compress_command, camera_res);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (all_outputs() !== 18'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", all_outputs());
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_two_frames();
    bit ok;
    int d;
    send_cmd(1'b1, 3'b101, 4'd2);
    push_frames(2, 3'b101, 1'b1);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL two_frames_busy: got %b expected 1", busy);
    end
    run_frame(ok, d);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL two_frames_handshake1: got ok=%0d expected 1", ok);
    end
    pop_and_compare("two_frames_1");
    checks++;
    if ({busy, tx_trigger} !== 2'b10) begin
      failures++;
      $display("FAIL two_frames_gap_state: got busy,tx=%b expected 10", {busy, tx_trigger});
    end
    repeat (GAP_CYCLES) @(negedge clk);
    run_frame(ok, d);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL two_frames_handshake2: got ok=%0d expected 1", ok);
    end
    pop_and_compare("two_frames_2");
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL two_frames_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_rep_zero_drain();
    int c;
    send_cmd(1'b0, 3'b011, 4'd0);
    push_frames(1, 3'b011, 1'b0);
    pulse_vsync();
    wait_cap(1'b1, 10, c);
    fifo_empty = 1'b0;
    repeat (40) @(negedge clk);
    pulse_vsync();
    wait_cap(1'b0, 10, c);
    fifo_empty = 1'b1;
    repeat (10) @(negedge clk);
    fifo_empty = 1'b0;
    @(negedge clk);
    fifo_empty = 1'b1;
    wait_frame(DRAIN_IDLE + 10, c);
    checks++;
    if (c != DRAIN_IDLE) begin
      failures++;
      $display("FAIL drain_consecutive: got %0d cycles expected %0d", c, DRAIN_IDLE);
    end
    pop_and_compare("rep_zero");
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rep_zero_single: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_gap_timeout();
    bit ok;
    int d;
    int hit;
    send_cmd(1'b0, 3'b010, 4'd2);
    push_frames(1, 3'b010, 1'b0);
    run_frame(ok, d);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL gap_handshake: got ok=%0d expected 1", ok);
    end
    pop_and_compare("gap_frame1");
    hit = -1;
    for (int i = 1; i <= GAP_CYCLES + ARM_TIMEOUT + 20; i++) begin
      if (timeout === 1'b1) begin
        hit = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (hit != GAP_CYCLES + ARM_TIMEOUT) begin
      failures++;
      $display("FAIL gap_length: got timeout at %0d expected %0d", hit, GAP_CYCLES + ARM_TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if ({busy, frame_count} !== {1'b0, fc_model}) begin
      failures++;
      $display("FAIL gap_abort_idle: got busy=%b fc=%0d expected busy=0 fc=%0d", busy, frame_count, fc_model);
    end
  endtask

  task automatic test_timeout();
    int hit;
    int c;
    send_cmd(1'b1, 3'b001, 4'd1);
    hit = -1;
    for (int i = 1; i <= ARM_TIMEOUT + 20; i++) begin
      if (timeout === 1'b1) begin
        hit = i;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (hit != ARM_TIMEOUT) begin
      failures++;
      $display("FAIL timeout_cycle: got %0d expected %0d", hit, ARM_TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if ({busy, timeout} !== 2'b00) begin
      failures++;
      $display("FAIL timeout_pulse_end: got busy,timeout=%b expected 00", {busy, timeout});
    end
    // Land the synchronized vsync edge on the very cycle the timeout would fire.
    send_cmd(1'b1, 3'b001, 4'd1);
    push_frames(1, 3'b001, 1'b1);
    repeat (ARM_TIMEOUT - 3) @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, timeout} !== 2'b10) begin
      failures++;
      $display("FAIL vsync_wins_no_timeout: got busy,timeout=%b expected 10", {busy, timeout});
    end
    @(negedge clk);
    vsync = 1'b0;
    checks++;
    if (capture_en !== 1'b1) begin
      failures++;
      $display("FAIL vsync_wins_capture: got %b expected 1", capture_en);
    end
    fifo_empty = 1'b0;
    repeat (40) @(negedge clk);
    pulse_vsync();
    wait_cap(1'b0, 10, c);
    fifo_empty = 1'b1;
    wait_frame(DRAIN_IDLE + 10, c);
    pop_and_compare("vsync_wins_frame");
  endtask

  task automatic test_cmd_dropped();
    int c;
    send_cmd(1'b1, 3'b111, 4'd1);
    push_frames(1, 3'b111, 1'b1);
    pulse_vsync();
    wait_cap(1'b1, 10, c);
    fifo_empty = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_resolution = 1'b0;
    cmd_compression = 3'b001;
    cmd_repetition = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cmd_dropped !== 1'b1) begin
      failures++;
      $display("FAIL drop_pulse: got %b expected 1", cmd_dropped);
    end
    @(negedge clk);
    checks++;
    if (cmd_dropped !== 1'b0) begin
      failures++;
      $display("FAIL drop_pulse_width: got %b expected 0", cmd_dropped);
    end
    checks++;
    if ({compress_command, camera_res} !== {3'b111, 1'b1}) begin
      failures++;
      $display("FAIL drop_fields: got comp=%0d res=%b expected comp=7 res=1", compress_command, camera_res);
    end
    repeat (30) @(negedge clk);
    pulse_vsync();
    wait_cap(1'b0, 10, c);
    fifo_empty = 1'b1;
    wait_frame(DRAIN_IDLE + 10, c);
    pop_and_compare("drop_frame");
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_rep_kept: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_overflow();
    int c;
    send_cmd(1'b0, 3'b100, 4'd1);
    push_frames(1, 3'b100, 1'b0);
    pulse_vsync();
    wait_cap(1'b1, 10, c);
    fifo_empty = 1'b0;
    repeat (10) @(negedge clk);
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: got %b expected 1", overflow);
    end
`ifdef FRAME_SCHED_OVERFLOW_ABORT_EN
    checks++;
    if ({capture_en, tx_trigger} !== 2'b01) begin
      failures++;
      $display("FAIL overflow_abort: got cap,tx=%b expected 01", {capture_en, tx_trigger});
    end
`else
    checks++;
    if (capture_en !== 1'b1) begin
      failures++;
      $display("FAIL overflow_continue: got %b expected 1", capture_en);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (capture_en !== 1'b1) begin
      failures++;
      $display("FAIL overflow_capture_holds: got %b expected 1", capture_en);
    end
    pulse_vsync();
    wait_cap(1'b0, 10, c);
`endif
    fifo_empty = 1'b1;
    wait_frame(DRAIN_IDLE + 10, c);
    pop_and_compare("overflow_frame");
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_reset_async();
    int c;
    send_cmd(1'b1, 3'b110, 4'd1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_cleared: got %b expected 0", overflow);
    end
    pulse_vsync();
    wait_cap(1'b1, 10, c);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({capture_en, tx_trigger, frame_count} !== 10'd0) begin
      failures++;
      $display("FAIL reset_mid_capture: got cap=%b tx=%b fc=%0d expected all 0", capture_en, tx_trigger, frame_count);
    end
    fc_model = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(1'b1, 3'b110, 4'd1);
    pulse_vsync();
    wait_cap(1'b1, 10, c);
    fifo_empty = 1'b0;
    repeat (20) @(negedge clk);
    pulse_vsync();
    wait_cap(1'b0, 10, c);
    for (int i = 0; i < 6; i++) begin
      fifo_empty = ~fifo_empty;
      @(negedge clk);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outputs() !== 18'd0) begin
      failures++;
      $display("FAIL reset_mid_drain: got %h expected 0", all_outputs());
    end
    @(negedge clk);
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, tx_trigger, capture_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_release_idle: got busy,tx,cap=%b expected 000", {busy, tx_trigger, capture_en});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_rep_zero_drain();
    test_gap_timeout();
    test_timeout();
    test_cmd_dropped();
    test_overflow();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
